// File: rtl/spi_pkg.sv
// spi_pkg: command encodings, frame sizes and master FSM states shared by the SPI master and slave.
package spi_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int FRAME_BITS = 10;
    localparam int RX_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        ROUTE,
        SHIFT,
        TURN,
        RECV,
        GAP_WAIT
    } state_e;

endpackage

// File: rtl/spi_master.sv
// spi_master: turns valid/ready commands into framed SPI transfers on the shared system clock.
module spi_master #(
    parameter int TURNAROUND = 2,
    parameter int GAP        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_type,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);
    import spi_pkg::*;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]   tx_q, tx_d;
    logic [RX_BITS-1:0]      rx_q, rx_d;
    logic                    is_rd_q, is_rd_d;
    logic                    ss_n_q, ss_n_d;
    logic                    mosi_q, mosi_d;
    logic                    ready_q, ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [RX_BITS-1:0]      rsp_data_q, rsp_data_d;
    logic                    busy_q, busy_d;

    // Outputs are computed from the next state so SS_n/MOSI/cmd_ready are plain flops.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        is_rd_d     = is_rd_q;
        mosi_d      = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: if (cmd_valid && ready_q) begin
                state_d = SELECT;
                tx_d    = {cmd_type, cmd_data};
                is_rd_d = (cmd_type == CMD_RD_DATA);
                busy_d  = 1'b1;
            end
            SELECT: begin
                state_d = ROUTE;
                mosi_d  = tx_q[FRAME_BITS-1];
            end
            ROUTE: begin
                state_d = SHIFT;
                cnt_d   = 4'(FRAME_BITS - 1);
                mosi_d  = tx_q[FRAME_BITS-1];
            end
            SHIFT: if (cnt_q == 4'd0) begin
                state_d = is_rd_q ? TURN : GAP_WAIT;
                cnt_d   = is_rd_q ? 4'(TURNAROUND - 1) : 4'(GAP - 1);
            end else begin
                cnt_d  = cnt_q - 4'd1;
                tx_d   = tx_q << 1;
                mosi_d = tx_q[FRAME_BITS-2];
            end
            TURN: if (cnt_q == 4'd0) begin
                state_d = RECV;
                cnt_d   = 4'(RX_BITS - 1);
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            RECV: begin
                rx_d = {rx_q[RX_BITS-2:0], MISO};
                if (cnt_q == 4'd0) begin
                    state_d     = GAP_WAIT;
                    cnt_d       = 4'(GAP - 1);
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = {rx_q[RX_BITS-2:0], MISO};
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            GAP_WAIT: if (cnt_q == 4'd0) begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            default: begin
                state_d = GAP_WAIT;
                cnt_d   = 4'(GAP - 1);
            end
        endcase
        ss_n_d  = (state_d == IDLE) || (state_d == GAP_WAIT);
        ready_d = (state_d == IDLE);
    end

    // Reset restarts a full gap so the slave always sees SS_n high for GAP clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= GAP_WAIT;
            cnt_q       <= 4'(GAP - 1);
            tx_q        <= '0;
            rx_q        <= '0;
            is_rd_q     <= 1'b0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            is_rd_q     <= is_rd_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: three masters (TURNAROUND 1/2/5) each talking to a behavioural slave+RAM model.
module tb_spi_master;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] cmd_valid = 3'b000;
    logic [1:0] cmd_type = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic [2:0] cmd_ready, rsp_valid, busy, ss_n, mosi;
    logic [2:0] miso = 3'b000;
    logic [7:0] rsp_data [3];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            spi_master #(
                .TURNAROUND((g == 0) ? 1 : (g == 1) ? 2 : 5),
                .GAP((g == 2) ? 3 : 1)
            ) u_dut (
                .clk(clk),
                .rst_n(rst_n),
                .cmd_valid(cmd_valid[g]),
                .cmd_ready(cmd_ready[g]),
                .cmd_type(cmd_type),
                .cmd_data(cmd_data),
                .rsp_valid(rsp_valid[g]),
                .rsp_data(rsp_data[g]),
                .busy(busy[g]),
                .SS_n(ss_n[g]),
                .MOSI(mosi[g]),
                .MISO(miso[g])
            );
        end
    endgenerate

    function automatic int ta_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 5;
    endfunction

    function automatic int gap_of(input int i);
        return (i == 2) ? 3 : 1;
    endfunction

    // Expected MOSI over the 12 SS_n-low clocks carrying data: idle 0, branch bit, then type and payload.
    function automatic logic [11:0] exp_frame(input logic [1:0] t, input logic [7:0] d);
        return {1'b0, t[1], t, d};
    endfunction

    int checks = 0;
    int errors = 0;

    // Slave model state, one per master
    int          k [3];
    int          hi [3];
    int          last_len [3];
    int          last_gap [3];
    int          prev_gap [3];
    int          frames [3];
    int          rsp_cnt [3];
    logic [11:0] fb [3];
    logic [11:0] last_fb [3];
    logic [7:0]  last_rsp [3];
    logic [7:0]  mem [3][256];
    logic [7:0]  waddr [3];
    logic [7:0]  raddr [3];
    logic        init_done = 1'b0;

    logic        force_en = 1'b0;
    logic [7:0]  force_byte = 8'h00;
    int          off = 0;

    always @(negedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 3; i++) begin
                for (int a = 0; a < 256; a++) mem[i][a] = 8'h00;
                waddr[i] = 8'h00;
                raddr[i] = 8'h00;
                fb[i] = '0;
                last_fb[i] = '0;
                last_rsp[i] = 8'h00;
            end
            init_done = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            int j;
            logic [7:0] src;
            if (rsp_valid[i]) begin
                rsp_cnt[i]++;
                last_rsp[i] = rsp_data[i];
            end
            if (!ss_n[i]) begin
                if (k[i] == 0) begin
                    prev_gap[i] = last_gap[i];
                    last_gap[i] = hi[i];
                    hi[i] = 0;
                end
                if (k[i] < 12) fb[i] = {fb[i][10:0], mosi[i]};
                j = k[i] - (12 + ta_of(i) + off);
                src = force_en ? force_byte : mem[i][raddr[i]];
                miso[i] = (j >= 0 && j < 8) ? src[7-j] : 1'b0;
                k[i]++;
            end else begin
                miso[i] = 1'b0;
                if (k[i] > 0) begin
                    last_len[i] = k[i];
                    last_fb[i] = fb[i];
                    frames[i]++;
                    if (k[i] >= 12) begin
                        case (fb[i][9:8])
                            CMD_WR_ADDR: waddr[i] = fb[i][7:0];
                            CMD_WR_DATA: mem[i][waddr[i]] = fb[i][7:0];
                            CMD_RD_ADDR: raddr[i] = fb[i][7:0];
                            default: ;
                        endcase
                    end
                    k[i] = 0;
                end
                hi[i]++;
            end
        end
    end

    task automatic send(input logic [2:0] mask, input logic [1:0] t, input logic [7:0] d);
        logic [2:0] pend, acc;
        int n;
        cmd_type = t;
        cmd_data = d;
        pend = mask;
        cmd_valid = mask;
        n = 0;
        while (pend != 3'b000 && n < 300) begin
            acc = pend & cmd_ready;
            @(negedge clk);
            pend = pend & ~acc;
            cmd_valid = pend;
            n++;
        end
        checks++;
        if (pend !== 3'b000) begin
            errors++;
            $display("FAIL send_accept pending=%b required 000", pend);
            cmd_valid = 3'b000;
        end
    endtask

    task automatic wait_idle(input logic [2:0] mask);
        int n = 0;
        while (((busy & mask) != 3'b000 || (cmd_ready & mask) != mask) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL wait_idle busy=%b ready=%b required idle", busy, cmd_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 3'b000;
        repeat (3) @(negedge clk);
        checks++; if (ss_n !== 3'b111) begin errors++; $display("FAIL reset_ss_n got %b want 111", ss_n); end
        checks++; if (mosi !== 3'b000) begin errors++; $display("FAIL reset_mosi got %b want 000", mosi); end
        checks++; if (cmd_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got %b want 000", cmd_ready); end
        checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL reset_rsp_valid got %b want 000", rsp_valid); end
        checks++; if (busy !== 3'b000) begin errors++; $display("FAIL reset_busy got %b want 000", busy); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rsp_data[i] !== 8'h00) begin errors++; $display("FAIL reset_rsp_data[%0d] got %h want 00", i, rsp_data[i]); end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 3'b011) begin errors++; $display("FAIL ready_after_gap1 got %b want 011", cmd_ready); end
        @(negedge clk);
        checks++; if (cmd_ready[2] !== 1'b0) begin errors++; $display("FAIL ready_early_gap3 got %b want 0", cmd_ready[2]); end
        @(negedge clk);
        checks++; if (cmd_ready !== 3'b111) begin errors++; $display("FAIL ready_after_gap3 got %b want 111", cmd_ready); end
        checks++; if (busy !== 3'b000) begin errors++; $display("FAIL idle_busy got %b want 000", busy); end
    endtask

    task automatic test_write_addr(input logic [7:0] a);
        int r0 [3];
        for (int i = 0; i < 3; i++) r0[i] = rsp_cnt[i];
        send(3'b111, CMD_WR_ADDR, a);
        wait_idle(3'b111);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (last_len[i] !== 12) begin errors++; $display("FAIL wa_len[%0d] got %0d want 12", i, last_len[i]); end
            checks++;
            if (last_fb[i] !== exp_frame(CMD_WR_ADDR, a)) begin
                errors++; $display("FAIL wa_bits[%0d] got %b want %b", i, last_fb[i], exp_frame(CMD_WR_ADDR, a));
            end
            checks++;
            if (rsp_cnt[i] !== r0[i]) begin errors++; $display("FAIL wa_no_rsp[%0d] got %0d want %0d", i, rsp_cnt[i], r0[i]); end
        end
    endtask

    task automatic test_write_read(input logic [7:0] d, input logic [7:0] a);
        int r0 [3];
        for (int i = 0; i < 3; i++) r0[i] = rsp_cnt[i];
        send(3'b111, CMD_WR_ADDR, a); wait_idle(3'b111);
        send(3'b111, CMD_WR_DATA, d); wait_idle(3'b111);
        send(3'b111, CMD_RD_ADDR, a); wait_idle(3'b111);
        send(3'b111, CMD_RD_DATA, 8'($urandom)); wait_idle(3'b111);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rsp_cnt[i] !== r0[i] + 1) begin errors++; $display("FAIL wr_rd_count[%0d] got %0d want %0d", i, rsp_cnt[i], r0[i] + 1); end
            checks++;
            if (last_rsp[i] !== d) begin errors++; $display("FAIL wr_rd_data[%0d] got %h want %h", i, last_rsp[i], d); end
            checks++;
            if (last_len[i] !== 20 + ta_of(i)) begin errors++; $display("FAIL rd_len[%0d] got %0d want %0d", i, last_len[i], 20 + ta_of(i)); end
        end
    endtask

    task automatic test_ta_sweep(input logic [7:0] b);
        logic [7:0] want;
        force_en = 1'b1;
        force_byte = b;
        for (int o = 0; o < 2; o++) begin
            off = o;
            want = (o == 0) ? b : {1'b0, b[7:1]};
            send(3'b111, CMD_RD_DATA, 8'($urandom));
            wait_idle(3'b111);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (last_rsp[i] !== want) begin
                    errors++; $display("FAIL ta_sweep[%0d] off=%0d got %h want %h", i, o, last_rsp[i], want);
                end
            end
        end
        off = 0;
        force_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        int f0 [3];
        int r0 [3];
        for (int i = 0; i < 3; i++) begin f0[i] = frames[i]; r0[i] = rsp_cnt[i]; end
        for (int n = 0; n < 3; n++) send(3'b111, 2'($urandom_range(0, 2)), 8'($urandom));
        wait_idle(3'b111);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (frames[i] !== f0[i] + 3) begin errors++; $display("FAIL b2b_frames[%0d] got %0d want %0d", i, frames[i], f0[i] + 3); end
            checks++;
            if (prev_gap[i] !== gap_of(i) + 1) begin errors++; $display("FAIL b2b_gap2[%0d] got %0d want %0d", i, prev_gap[i], gap_of(i) + 1); end
            checks++;
            if (last_gap[i] !== gap_of(i) + 1) begin errors++; $display("FAIL b2b_gap3[%0d] got %0d want %0d", i, last_gap[i], gap_of(i) + 1); end
            checks++;
            if (rsp_cnt[i] !== r0[i]) begin errors++; $display("FAIL b2b_no_rsp[%0d] got %0d want %0d", i, rsp_cnt[i], r0[i]); end
        end
    endtask

    task automatic test_busy_drop();
        int f0 [3];
        for (int i = 0; i < 3; i++) f0[i] = frames[i];
        send(3'b111, CMD_WR_ADDR, 8'($urandom));
        cmd_type = CMD_WR_DATA;
        cmd_data = 8'($urandom);
        for (int n = 0; n < 4; n++) begin
            cmd_valid = 3'b111;
            @(negedge clk);
            cmd_valid = 3'b000;
            @(negedge clk);
        end
        wait_idle(3'b111);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (frames[i] !== f0[i] + 1) begin errors++; $display("FAIL busy_drop[%0d] frames got %0d want %0d", i, frames[i], f0[i] + 1); end
        end
        checks++; if (busy !== 3'b000) begin errors++; $display("FAIL busy_drop_busy got %b want 000", busy); end
    endtask

    task automatic test_reset_mid_shift();
        int r0 [3];
        logic [7:0] a;
        for (int i = 0; i < 3; i++) r0[i] = rsp_cnt[i];
        send(3'b111, CMD_WR_DATA, 8'($urandom));
        repeat (7) @(posedge clk);
        #2;
        checks++; if (ss_n !== 3'b000) begin errors++; $display("FAIL mid_shift_active got %b want 000", ss_n); end
        rst_n = 1'b0;
        #1;
        checks++; if (ss_n !== 3'b111) begin errors++; $display("FAIL async_ss_n got %b want 111", ss_n); end
        checks++; if (busy !== 3'b000) begin errors++; $display("FAIL async_busy got %b want 000", busy); end
        checks++; if (mosi !== 3'b000) begin errors++; $display("FAIL async_mosi got %b want 000", mosi); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle(3'b111);
        a = 8'($urandom);
        send(3'b111, CMD_WR_ADDR, a);
        wait_idle(3'b111);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (last_fb[i] !== exp_frame(CMD_WR_ADDR, a) || last_len[i] !== 12) begin
                errors++; $display("FAIL post_reset_frame[%0d] got %b/%0d want %b/12", i, last_fb[i], last_len[i], exp_frame(CMD_WR_ADDR, a));
            end
            checks++;
            if (rsp_cnt[i] !== r0[i]) begin errors++; $display("FAIL reset_no_rsp[%0d] got %0d want %0d", i, rsp_cnt[i], r0[i]); end
        end
    endtask

    task automatic test_rd_no_addr();
        int r0 [3];
        int first [3];
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_idle(3'b111);
        for (int i = 0; i < 3; i++) begin r0[i] = rsp_cnt[i]; first[i] = -1; end
        send(3'b111, CMD_RD_DATA, 8'($urandom));
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (!busy[i] && first[i] < 0) first[i] = c;
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (first[i] !== 20 + ta_of(i) + gap_of(i)) begin
                errors++; $display("FAIL busy_schedule[%0d] got %0d want %0d", i, first[i], 20 + ta_of(i) + gap_of(i));
            end
            checks++;
            if (rsp_cnt[i] !== r0[i] + 1) begin errors++; $display("FAIL noaddr_rsp[%0d] got %0d want %0d", i, rsp_cnt[i], r0[i] + 1); end
            checks++;
            if (last_rsp[i] !== mem[i][raddr[i]]) begin errors++; $display("FAIL noaddr_data[%0d] got %h want %h", i, last_rsp[i], mem[i][raddr[i]]); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_write_addr(8'hA5);
        test_write_read(8'h3C, 8'hA5);
        for (int n = 0; n < 2; n++) test_write_read(8'($urandom), 8'($urandom));
        test_ta_sweep(8'h96);
        test_ta_sweep(8'($urandom));
        test_back_to_back();
        test_busy_drop();
        test_reset_mid_shift();
        test_rd_no_addr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
